// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if
//   Bundles the instruction-field handshake, the instruction-memory write
//   port and the session status flags of instr_encoder_loader.
//   master : field producer / memory side (drives start and the in_* fields)
//   slave  : the loader itself
// Parameter ADDR_WIDTH must match the loader's ADDR_WIDTH (word_count is
// ADDR_WIDTH+1 bits so that a full memory can be counted).
interface instr_encoder_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [2:0]            in_class;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [2:0]            in_func3;
  logic                  in_func7b5;
  logic [31:0]           in_imm;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  busy;
  logic                  full;
  logic                  done;
  logic                  err;

  modport master (
    output start, in_valid, in_last, in_class, in_rd, in_rs1, in_rs2,
           in_func3, in_func7b5, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, full,
           done, err
  );

  modport slave (
    input  start, in_valid, in_last, in_class, in_rd, in_rs1, in_rs2,
           in_func3, in_func7b5, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, full,
           done, err
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Encodes one decoded RV32I instruction description per handshake into the
//   32-bit machine word and writes the words to consecutive instruction-memory
//   word slots starting at byte address MEM_BASE.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; aborts a session immediately
//   bus  - instr_encoder_loader_if.slave: start, in_* field handshake,
//          mem_we/mem_addr/mem_wdata write port, word_count/busy/full/done/err
// Optional feature:
//   ENC_CHECK_EN - when defined, B-class (odd immediate or func3 010/011) and
//                  JAL (odd immediate) fields are rejected with an err pulse.
//                  When undefined, err is constant 0 and stray bits are dropped.
module instr_encoder_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] MEM_BASE   = 32'h0
) (
  input logic                    clk,
  input logic                    rst,
  instr_encoder_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LAST_SLOT = CAPACITY - 1'b1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t              state;
  // The slot counter doubles as word_count: every write fills the next slot,
  // and rejected fields advance neither.
  logic [ADDR_WIDTH:0] count;
  logic                last_reg;
  logic                we_reg;
  logic                done_reg;
  logic                err_reg;
  logic [31:0]         addr_reg;
  logic [31:0]         wdata_reg;

  logic                full;
  logic                accept;
  logic                reject;
  logic [31:0]         enc_word;
  logic [31:0]         slot_addr;

  assign full      = (count == CAPACITY);
  assign accept    = (state == LOAD) && bus.in_valid && !full;
  assign slot_addr = MEM_BASE + (32'(count) << 2);

  // Field-to-word assembly; unused fields are left zero per format.
  always_comb begin
    enc_word = 32'h0;
    case (bus.in_class)
      3'd0: enc_word = {1'b0, bus.in_func7b5, 5'b0, bus.in_rs2, bus.in_rs1,
                        bus.in_func3, bus.in_rd, OP_R};
      3'd1: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_func3,
                        bus.in_rd, OP_I};
      3'd2: enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b000,
                        bus.in_rd, OP_JALR};
      3'd3: enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b010,
                        bus.in_rd, OP_LW};
      3'd4: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010,
                        bus.in_imm[4:0], OP_S};
      3'd5: enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                        bus.in_imm[19:12], bus.in_rd, OP_JAL};
      3'd6: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2,
                        bus.in_rs1, bus.in_func3, bus.in_imm[4:1],
                        bus.in_imm[11], OP_B};
      default: enc_word = {bus.in_imm[31:12], bus.in_rd, OP_LUI};
    endcase
  end

`ifdef ENC_CHECK_EN
  // Branch targets must be halfword aligned and func3 010/011 are not
  // branch conditions; JAL targets must be halfword aligned.
  assign reject = ((bus.in_class == 3'd6) &&
                   (bus.in_imm[0] || (bus.in_func3[2:1] == 2'b01))) ||
                  ((bus.in_class == 3'd5) && bus.in_imm[0]);
`else
  logic unused_imm_lsb;
  assign unused_imm_lsb = bus.in_imm[0];
  assign reject         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      last_reg  <= 1'b0;
      we_reg    <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
    end else begin
      we_reg   <= 1'b0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD;
            count <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (reject) begin
              err_reg <= 1'b1;
              if (bus.in_last) begin
                state    <= DONE;
                done_reg <= 1'b1;
              end
            end else begin
              wdata_reg <= enc_word;
              addr_reg  <= slot_addr;
              last_reg  <= bus.in_last;
              we_reg    <= 1'b1;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          count <= count + 1'b1;
          // Filling the last slot ends the session so the counter never wraps.
          if (last_reg || (count == LAST_SLOT)) begin
            state    <= DONE;
            done_reg <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = (state == LOAD) && !full;
  assign bus.mem_we     = we_reg;
  assign bus.mem_addr   = addr_reg;
  assign bus.mem_wdata  = wdata_reg;
  assign bus.word_count = count;
  assign bus.busy       = (state != IDLE);
  assign bus.full       = full;
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader
//   Directed bench for instr_encoder_loader. Two instances: a 256-word loader
//   based at 0x1000 for encoding/session checks and a 4-word loader at 0 for
//   the fill-to-capacity case. Writes, done and err pulses are logged by
//   negedge monitors; the stimulus compares them with hand-encoded words.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_WIDTH(8)) b1 ();
  instr_encoder_loader_if #(.ADDR_WIDTH(2)) b2 ();

  instr_encoder_loader #(.ADDR_WIDTH(8), .MEM_BASE(32'h0000_1000)) dut (
    .clk(clk), .rst(rst), .bus(b1)
  );
  instr_encoder_loader #(.ADDR_WIDTH(2), .MEM_BASE(32'h0)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  int total = 0;
  int bad   = 0;

  int          wr_n = 0, done_n = 0, err_n = 0;
  int          wr2_n = 0, done2_n = 0;
  logic [31:0] wa [64];
  logic [31:0] wd [64];
  logic [31:0] last2_addr = 32'h0;

  always @(negedge clk) begin
    if (b1.mem_we && wr_n < 64) begin
      wa[wr_n] <= b1.mem_addr;
      wd[wr_n] <= b1.mem_wdata;
      wr_n     <= wr_n + 1;
      $display("write1 addr=%h data=%h", b1.mem_addr, b1.mem_wdata);
    end
    if (b1.done) done_n <= done_n + 1;
    if (b1.err)  err_n  <= err_n + 1;
    if (b2.mem_we) begin
      wr2_n      <= wr2_n + 1;
      last2_addr <= b2.mem_addr;
      $display("write2 addr=%h data=%h", b2.mem_addr, b2.mem_wdata);
    end
    if (b2.done) done2_n <= done2_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start;
    b1.start = 1'b1;
    tick(1);
    b1.start = 1'b0;
  endtask

  // Presents one field set, waits (bounded) for in_ready, and returns just
  // after the accepting edge, i.e. inside the WRITE cycle.
  task automatic send(input logic [2:0] cls, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic f7,
                      input logic [31:0] imm, input logic last);
    logic ok;
    b1.in_class = cls; b1.in_rd = rd; b1.in_rs1 = rs1; b1.in_rs2 = rs2;
    b1.in_func3 = f3; b1.in_func7b5 = f7; b1.in_imm = imm;
    b1.in_last = last; b1.in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (b1.in_ready) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("accept_wait", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
    b1.in_last  = 1'b0;
    $display("send class=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h last=%0b",
             cls, rd, rs1, rs2, f3, imm, last);
  endtask

  initial begin
    int base;
    logic [31:0] exp_w [6];
    exp_w = '{32'hFE208EE3, 32'h008000EF, 32'h123452B7,
              32'h402081B3, 32'h00412283, 32'h00008067};

    b1.start = 0; b1.in_valid = 0; b1.in_last = 0; b1.in_class = 0;
    b1.in_rd = 0; b1.in_rs1 = 0; b1.in_rs2 = 0; b1.in_func3 = 0;
    b1.in_func7b5 = 0; b1.in_imm = 0;
    b2.start = 0; b2.in_valid = 0; b2.in_last = 0; b2.in_class = 0;
    b2.in_rd = 0; b2.in_rs1 = 0; b2.in_rs2 = 0; b2.in_func3 = 0;
    b2.in_func7b5 = 0; b2.in_imm = 0;

    rst = 1'b1;
    tick(2);
    check("rst_in_ready", 32'(b1.in_ready), 32'd0);
    check("rst_busy", 32'(b1.busy), 32'd0);
    check("rst_mem_we", 32'(b1.mem_we), 32'd0);
    check("rst_word_count", 32'(b1.word_count), 32'd0);
    check("rst_done_err", 32'({b1.done, b1.err, b1.full}), 32'd0);
    check("rst_mem_addr", b1.mem_addr, 32'h0);
    check("rst_mem_wdata", b1.mem_wdata, 32'h0);
    rst = 1'b0;
    tick(1);

    // in_valid without start: loader stays idle
    b1.in_class = 3'd1; b1.in_rd = 5'd1; b1.in_imm = 32'd5; b1.in_valid = 1'b1;
    tick(3);
    check("idle_in_ready", 32'(b1.in_ready), 32'd0);
    check("idle_no_write", 32'(wr_n), 32'd0);
    b1.in_valid = 1'b0;

    // addi x1,x0,5 ; sw x2,8(x1)
    pulse_start;
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8, 1'b1);
    tick(3);
    check("s1_writes", 32'(wr_n), 32'd2);
    check("s1_addr0", wa[0], 32'h0000_1000);
    check("s1_data0", wd[0], 32'h0050_0093);
    check("s1_addr1", wa[1], 32'h0000_1004);
    check("s1_data1", wd[1], 32'h0020_A423);
    check("s1_done", 32'(done_n), 32'd1);
    check("s1_word_count", 32'(b1.word_count), 32'd2);
    check("s1_busy", 32'(b1.busy), 32'd0);

    // all formats, ignored fields driven non-zero, start pulsed mid-session
    base = wr_n;
    pulse_start;
    send(3'd6, 5'd9, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    tick(2);
    pulse_start;
    check("ign_start_busy", 32'(b1.busy), 32'd1);
    check("ign_start_count", 32'(b1.word_count), 32'd1);
    send(3'd5, 5'd1, 5'd6, 5'd7, 3'd3, 1'b0, 32'd8, 1'b0);
    send(3'd7, 5'd5, 5'd3, 5'd4, 3'd6, 1'b1, 32'h1234_5000, 1'b0);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    send(3'd3, 5'd5, 5'd2, 5'd9, 3'd7, 1'b0, 32'd4, 1'b0);
    send(3'd2, 5'd0, 5'd1, 5'd7, 3'd5, 1'b0, 32'd0, 1'b1);
    tick(3);
    check("s2_writes", 32'(wr_n - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s2_addr%0d", i), wa[base+i], 32'h1000 + 32'(4*i));
      check($sformatf("s2_data%0d", i), wd[base+i], exp_w[i]);
    end
    check("s2_done", 32'(done_n), 32'd2);
    check("s2_word_count", 32'(b1.word_count), 32'd6);

    // misaligned branch immediate
    base = wr_n;
    pulse_start;
    send(3'd6, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, 1'b0);
    tick(2);
`ifdef ENC_CHECK_EN
    check("chk_err", 32'(err_n), 32'd1);
    check("chk_no_write", 32'(wr_n - base), 32'd0);
    check("chk_word_count", 32'(b1.word_count), 32'd0);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1);
    tick(3);
    check("chk_next_writes", 32'(wr_n - base), 32'd1);
    check("chk_next_addr", wa[base], 32'h0000_1000);
    check("chk_next_data", wd[base], 32'h0050_0093);
`else
    check("nochk_err", 32'(err_n), 32'd0);
    check("nochk_write", 32'(wr_n - base), 32'd1);
    check("nochk_data", wd[base], 32'h0020_8163);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1);
    tick(3);
    check("nochk_next_addr", wa[base+1], 32'h0000_1004);
    check("nochk_next_data", wd[base+1], 32'h0050_0093);
`endif

    // reset asserted during a WRITE cycle
    base = wr_n;
    pulse_start;
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
    send(3'd3, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd4, 1'b0);
    check("mid_we_high", 32'(b1.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_we_drop", 32'(b1.mem_we), 32'd0);
    check("mid_busy", 32'(b1.busy), 32'd0);
    check("mid_word_count", 32'(b1.word_count), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    check("mid_writes", 32'(wr_n - base), 32'd1);
    base = wr_n;
    pulse_start;
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b1);
    tick(3);
    check("post_rst_writes", 32'(wr_n - base), 32'd1);
    check("post_rst_addr", wa[base], 32'h0000_1000);
    check("post_rst_data", wd[base], 32'h0080_00EF);

    // 4-word loader, in_valid held high without in_last
    b2.in_class = 3'd1; b2.in_rd = 5'd1; b2.in_imm = 32'd5;
    b2.in_valid = 1'b1;
    b2.start = 1'b1;
    tick(1);
    b2.start = 1'b0;
    for (int k = 0; k < 40 && done2_n == 0; k++) tick(1);
    check("fill_done", 32'(done2_n), 32'd1);
    tick(3);
    check("fill_writes", 32'(wr2_n), 32'd4);
    check("fill_last_addr", last2_addr, 32'h0000_000C);
    check("fill_full", 32'(b2.full), 32'd1);
    check("fill_word_count", 32'(b2.word_count), 32'd4);
    check("fill_in_ready", 32'(b2.in_ready), 32'd0);
    check("fill_busy", 32'(b2.busy), 32'd0);
    b2.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
